// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard sequencer: load-use and MDU stalls, branch redirect
// flushes and halt drain for the 5-stage pipeline.
module pipeline_hazard_ctrl #(
  parameter int MDU_LATENCY  = 4,
  parameter int DRAIN_CYCLES = 3,
  parameter int REG_ADDR_W   = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_use_rs1,
  input  logic                  id_use_rs2,
  input  logic                  id_halt,
  input  logic                  ex_mem_read,
  input  logic [REG_ADDR_W-1:0] ex_rd,
  input  logic                  ex_mdu_start,
  input  logic                  ex_branch_taken,
  output logic                  pc_en,
  output logic                  ifid_en,
  output logic                  idex_en,
  output logic                  ifid_flush,
  output logic                  idex_flush,
  output logic                  exmem_flush,
  output logic                  pc_redirect,
  output logic                  halted
);

  localparam int MAXC =
    (MDU_LATENCY > DRAIN_CYCLES) ? MDU_LATENCY : DRAIN_CYCLES;
  localparam int CW = $clog2(MAXC + 1);
  localparam logic [CW-1:0] MDU_INIT = CW'(MDU_LATENCY - 2);
  localparam logic [CW-1:0] DRN_INIT = CW'(DRAIN_CYCLES - 1);
  localparam logic [CW-1:0] ONE      = CW'(1);

  typedef enum logic [1:0] {
    RUN, MDU_WAIT, DRAIN, HALTED
  } state_e;

  state_e        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          load_use;
  logic          run_cyc;
  logic          mdu_ok;

  assign load_use = ex_mem_read &&
    ((id_use_rs1 && (id_rs1 == ex_rd)) ||
     (id_use_rs2 && (id_rs2 == ex_rd)));

  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    exmem_flush = 1'b0;
    pc_redirect = 1'b0;
    halted      = 1'b0;
    state_d     = state_q;
    cnt_d       = cnt_q;
    run_cyc     = 1'b0;
    mdu_ok      = 1'b0;

    unique case (state_q)
      RUN: begin
        run_cyc = 1'b1;
        mdu_ok  = 1'b1;
      end
      MDU_WAIT: begin
        if (cnt_q != '0) begin
          pc_en       = 1'b0;
          ifid_en     = 1'b0;
          idex_en     = 1'b0;
          exmem_flush = 1'b1;
          cnt_d       = cnt_q - ONE;
        end else begin
          run_cyc = 1'b1;
          state_d = RUN;
        end
      end
      DRAIN: begin
        pc_en      = 1'b0;
        ifid_flush = 1'b1;
        if (cnt_q != '0) cnt_d = cnt_q - ONE;
        else             state_d = HALTED;
      end
      HALTED: begin
        pc_en   = 1'b0;
        ifid_en = 1'b0;
        idex_en = 1'b0;
        halted  = 1'b1;
      end
      default: state_d = RUN;
    endcase

    // Final MDU cycle shares RUN priorities but cannot restart the MDU
    if (run_cyc) begin
      if (ex_branch_taken) begin
        pc_redirect = 1'b1;
        ifid_flush  = 1'b1;
        idex_flush  = 1'b1;
      end else if (ex_mdu_start && mdu_ok) begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        idex_en     = 1'b0;
        exmem_flush = 1'b1;
        state_d     = MDU_WAIT;
        cnt_d       = MDU_INIT;
      end else if (load_use) begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_flush = 1'b1;
      end else if (id_halt) begin
        pc_en      = 1'b0;
        ifid_flush = 1'b1;
        state_d    = DRAIN;
        cnt_d      = DRN_INIT;
      end
    end

    if (rst) begin
      pc_en       = 1'b1;
      ifid_en     = 1'b1;
      idex_en     = 1'b1;
      ifid_flush  = 1'b0;
      idex_flush  = 1'b0;
      exmem_flush = 1'b0;
      pc_redirect = 1'b0;
      halted      = 1'b0;
      state_d     = RUN;
      cnt_d       = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
